// File: rtl/alu_input_sequencer.sv
// ALU input sequencer: the user commits A, B and the control word one at a
// time from shared data switches, each commit made by a debounced key press.
//
// state | meaning
// S_A   | waiting for press to load operand A
// S_B   | waiting for press to load operand B
// S_OP  | waiting for press to load ALU control
// S_RUN | A, B, ctrl committed; o_valid high

module alu_input_sequencer #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_key_n,
  input  logic         i_clear,
  input  logic [N-1:0] i_data,
  output logic [N-1:0] o_a,
  output logic [N-1:0] o_b,
  output logic [1:0]   o_ctrl,
  output logic         o_valid,
  output logic [1:0]   o_state,
  output logic         o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RUN = 2'd3
  } state_t;

  logic          key_m;
  logic          key_s;
  logic          deb;
  logic          deb_d;
  logic [CW-1:0] cnt;
  logic          press;

  state_t        state_q;
  state_t        state_d;
  logic [N-1:0]  a_d;
  logic [N-1:0]  b_d;
  logic [1:0]    ctrl_d;

  // Two-flop synchroniser; resets to the released (high) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
    end else begin
      key_m <= i_key_n;
      key_s <= key_m;
    end
  end

  // Debouncer: accept a new level only after it has differed from deb for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= 1'b1;
      cnt <= '0;
    end else if (key_s == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      deb <= key_s;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // press is the combinational falling-edge of deb; the sequencer and o_press both register it.
  assign press = deb_d & ~deb;

  // Delay deb for edge detection and register the debug press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_d   <= 1'b1;
      o_press <= 1'b0;
    end else begin
      deb_d   <= deb;
      o_press <= press;
    end
  end

  // Next-state and next-register logic; clear overrides a coincident press.
  always_comb begin
    state_d = state_q;
    a_d     = o_a;
    b_d     = o_b;
    ctrl_d  = o_ctrl;
    if (i_clear) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      ctrl_d  = '0;
    end else if (press) begin
      case (state_q)
        S_A: begin
          a_d     = i_data;
          state_d = S_B;
        end
        S_B: begin
          b_d     = i_data;
          state_d = S_OP;
        end
        S_OP: begin
          ctrl_d  = i_data[1:0];
          state_d = S_RUN;
        end
        default: begin
          state_d = S_A;
        end
      endcase
    end
  end

  // State and operand registers; o_valid tracks the next state so it matches S_RUN exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_A;
      o_a     <= '0;
      o_b     <= '0;
      o_ctrl  <= '0;
      o_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      o_a     <= a_d;
      o_b     <= b_d;
      o_ctrl  <= ctrl_d;
      o_valid <= (state_d == S_RUN);
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Scoreboard bench for alu_input_sequencer with DEBOUNCE_CYCLES=4, N=4.

module tb_alu_input_sequencer;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_n = 1'b1;
  logic         clear = 1'b0;
  logic [N-1:0] data = '0;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [1:0]   ctrl;
  logic         valid;
  logic [1:0]   state;
  logic         press;

  alu_input_sequencer #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_key_n (key_n),
    .i_clear (clear),
    .i_data  (data),
    .o_a     (a),
    .o_b     (b),
    .o_ctrl  (ctrl),
    .o_valid (valid),
    .o_state (state),
    .o_press (press)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] ctrl;
    logic       valid;
    logic [1:0] state;
    int         edge_no;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [3:0] m_a;
  logic [3:0] m_b;
  logic [1:0] m_ctrl;
  logic [1:0] m_state;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_ctrl = '0; m_state = 2'd0;
  endtask

  task automatic model_press(input logic [3:0] d);
    case (m_state)
      2'd0: begin m_a = d; m_state = 2'd1; end
      2'd1: begin m_b = d; m_state = 2'd2; end
      2'd2: begin m_ctrl = d[1:0]; m_state = 2'd3; end
      default: m_state = 2'd0;
    endcase
  endtask

  task automatic push_exp(input int edge_no);
    exp_t e;
    e.a = m_a; e.b = m_b; e.ctrl = m_ctrl;
    e.valid = (m_state == 2'd3);
    e.state = m_state;
    e.edge_no = edge_no;
    sb.push_back(e);
  endtask

  // Clean press: key low 10 cycles then released and allowed to settle.
  task automatic do_press(input logic [3:0] d, input bit check_latency);
    int e;
    @(posedge clk); #1;
    data = d;
    key_n = 1'b0;
    e = cyc;
    model_press(d);
    push_exp(check_latency ? e + 7 : -1);
    repeat (10) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  // Monitor: pop the scoreboard on every o_press and compare.
  logic prev_press = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) check("valid_vs_state", {31'd0, valid}, {31'd0, state == 2'd3});
    if (press === 1'b1) begin
      check("press_width", {31'd0, prev_press}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_press: got press at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("press_a", {28'd0, a}, {28'd0, e.a});
        check("press_b", {28'd0, b}, {28'd0, e.b});
        check("press_ctrl", {30'd0, ctrl}, {30'd0, e.ctrl});
        check("press_valid", {31'd0, valid}, {31'd0, e.valid});
        check("press_state", {30'd0, state}, {30'd0, e.state});
        if (e.edge_no >= 0) check("press_latency", cyc, e.edge_no);
      end
    end
    prev_press = press;
  end

  initial begin
    int e;

    // 1: reset and idle key
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a", {28'd0, a}, 32'd0);
    check("rst_b", {28'd0, b}, 32'd0);
    check("rst_ctrl", {30'd0, ctrl}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_press", {31'd0, press}, 32'd0);
    rst = 1'b0;
    model_reset();
    repeat (20) @(posedge clk);
    #1;
    check("idle_state", {30'd0, state}, 32'd0);

    // 2: full load then wrap
    do_press(4'h9, 1'b0);
    do_press(4'h5, 1'b0);
    do_press(4'h2, 1'b0);
    check("load_a", {28'd0, a}, 32'h9);
    check("load_b", {28'd0, b}, 32'h5);
    check("load_ctrl", {30'd0, ctrl}, 32'h2);
    check("load_valid", {31'd0, valid}, 32'd1);
    check("load_state", {30'd0, state}, 32'd3);
    do_press(4'hF, 1'b0);
    check("wrap_valid", {31'd0, valid}, 32'd0);
    check("wrap_state", {30'd0, state}, 32'd0);
    check("wrap_a_kept", {28'd0, a}, 32'h9);

    // 3: latency
    do_press(4'h3, 1'b1);
    check("lat_a", {28'd0, a}, 32'h3);
    check("lat_state", {30'd0, state}, 32'd1);

    // 4: bounce is ignored, then a held press is accepted once
    @(posedge clk); #1 key_n = 1'b0; data = 4'hE;
    repeat (3) @(posedge clk); #1 key_n = 1'b1;
    @(posedge clk); #1 key_n = 1'b0;
    repeat (3) @(posedge clk); #1 key_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("bounce_state", {30'd0, state}, 32'd1);
    check("bounce_b", {28'd0, b}, 32'h5);
    do_press(4'h7, 1'b1);
    check("held_b", {28'd0, b}, 32'h7);
    check("held_state", {30'd0, state}, 32'd2);

    // 5: clear coincident with press in S_OP
    @(posedge clk); #1;
    data = 4'h1;
    key_n = 1'b0;
    e = cyc;
    model_reset();
    push_exp(e + 7);
    repeat (6) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("clr_state", {30'd0, state}, 32'd0);
    check("clr_a", {28'd0, a}, 32'd0);
    check("clr_b", {28'd0, b}, 32'd0);
    check("clr_ctrl", {30'd0, ctrl}, 32'd0);
    check("clr_valid", {31'd0, valid}, 32'd0);

    // 6: reset during debounce restarts the full debounce
    do_press(4'h6, 1'b0);
    check("pre_rst_a", {28'd0, a}, 32'h6);
    @(posedge clk); #1;
    key_n = 1'b0;
    data = 4'hA;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    e = cyc;
    check("mid_rst_a", {28'd0, a}, 32'd0);
    check("mid_rst_state", {30'd0, state}, 32'd0);
    model_reset();
    model_press(4'hA);
    push_exp(e + 7);
    repeat (10) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_rst_a", {28'd0, a}, 32'hA);
    check("post_rst_state", {30'd0, state}, 32'd1);

    repeat (5) @(posedge clk);
    while (sb.size() != 0) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_press: got no press expected one at edge %0d", x.edge_no);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
